ctrl_flow_sequencer: RTL
========================

Name: ctrl_flow_sequencer

Overview:
- Parametrised control-step sequencer that replaces hand-coded bench FSMs.
- Drives the datapath strobes for instruction fetch and the control-flow instructions: jal, jr, conditional branch and halt.
- Inserts a configurable number of memory wait states during fetch.
- Sits beside the datapath: reads IR and CON back from it and drives its control inputs directly.

Parameters:
- BITS, 32, instruction/IR width.
- OP_BITS, 5, opcode width; opcode = ir[BITS-1 -: OP_BITS].
- READ_WAIT, 0, extra cycles T1 is held for a memory read (0..15).
- COUNT_BITS, 16, width of the retired-instruction counter (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  level; sequencer leaves IDLE and keeps fetching while high.
- ir  in  BITS  IR contents from the datapath.
- con  in  1  CON flag from the datapath branch-condition logic.
- PCout, MDRout, RZout, Cout, Rout  out  1 each  bus-drive enables.
- PCin, IRin, MDRin, MARin, RYin, RZin, CONin, Rin  out  1 each  register load enables.
- Gra, Grb  out  1 each  register-field selects.
- Read, IncPC, ADD  out  1 each  memory and ALU controls.
- halted  out  1  high while in HALT.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- step  out  4  current state encoding, for debug.

Behaviour:
- Reset (reset=0, async): state=IDLE, every output 0, wait counter 0. Asserting reset mid-instruction aborts immediately with no partial strobes.
- Outputs are Moore-registered: decoded from the state register, valid for the whole cycle.
- At most one bus-drive enable is high in any cycle.
- IDLE: if run=1 go to T0, else stay.
- T0: PCout, MARin, IncPC, RZin. Next state T1.
- T1: Read, MDRin held for READ_WAIT+1 cycles. On the final cycle also RZout and PCin (PC <- PC+1). Counter resets on T1 entry. Next state T2.
- T2: MDRout, IRin. Next state T3.
- T3: decode from the registered ir.
  - JR (5'b10100): Gra, Rout, PCin. Retire.
  - JAL (5'b10011): PCout, Grb, Rin (link Rb <- PC). Next state T4.
  - BR (5'b10010): Gra, Rout, CONin. Next state T4.
  - HALT (5'b11011): go to HALT.
  - Any other opcode: pulse illegal. Retire.
- T4:
  - JAL: Gra, Rout, PCin. Retire.
  - BR: PCout, RYin. Next state T5.
- T5 (BR only): Cout, ADD, RZin. Next state T6.
- T6 (BR only): RZout; PCin only if con=1 in this cycle. Retire.
- Retire: go to T0 if run=1, else IDLE. Dropping run mid-instruction always completes the current instruction first.
- HALT: halted=1, all strobes 0. Leave only through reset; run is ignored.
- The step encoding (IDLE=0, T0..T6=1..7, HALT=15) is fixed for debug visibility.
- The opcode field is OP_BITS wide, with the listed codes right-aligned. Opcode bits beyond 5 must be zero to match.

Optional Feature:
- Macro SEQ_RETIRE_COUNT_EN.
- When defined: adds output instr_count [COUNT_BITS-1:0]. Reset value 0. Increments by 1 on each retire (including illegal), wraps from all-ones to 0, and holds in HALT and IDLE.
- When undefined: the port and its logic are absent.

Test Plan:
- Reset/idle: reset=0 mid-T1, then release with run=0 -> all outputs 0, step=0, stays IDLE.
- Fetch latency: READ_WAIT=2, run=1 -> Read high exactly 3 cycles; PCin only in the third; IRin at cycle 5 after leaving IDLE.
- JAL: ir opcode 10011, Ra=R1, Rb=R15 -> T3 asserts PCout+Grb+Rin, T4 asserts Gra+Rout+PCin, then T0.
- Branch: BR with con=0 -> T6 has RZout, PCin=0. Repeat with con=1 -> PCin=1 in T6.
- Illegal/halt: opcode 00111 -> illegal pulses 1 cycle, next fetch starts. Opcode 11011 -> halted=1, held with run=1 until reset.
- Counter (SEQ_RETIRE_COUNT_EN, COUNT_BITS=2): 5 JR instructions -> instr_count 1,2,3,0,1.

Source files
------------

// File: rtl/ctrl_flow_sequencer.sv
// ============================================================================
// Module   : ctrl_flow_sequencer
// Purpose  : Control-step sequencer for instruction fetch, jal, jr, branch and
//            halt, with configurable memory wait states during fetch.
// Options  : SEQ_RETIRE_COUNT_EN adds the retired-instruction counter output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_flow_sequencer #(
    parameter int BITS       = 32,
    parameter int OP_BITS    = 5,
    parameter int READ_WAIT  = 0,
    parameter int COUNT_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic [BITS-1:0]       ir,
    input  logic                  con,
    output logic                  PCout,
    output logic                  MDRout,
    output logic                  RZout,
    output logic                  Cout,
    output logic                  Rout,
    output logic                  PCin,
    output logic                  IRin,
    output logic                  MDRin,
    output logic                  MARin,
    output logic                  RYin,
    output logic                  RZin,
    output logic                  CONin,
    output logic                  Rin,
    output logic                  Gra,
    output logic                  Grb,
    output logic                  Read,
    output logic                  IncPC,
    output logic                  ADD,
    output logic                  halted,
    output logic                  illegal,
    output logic [3:0]            step
`ifdef SEQ_RETIRE_COUNT_EN
    ,
    output logic [COUNT_BITS-1:0] instr_count
`endif
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd15
    } state_t;

    localparam logic [OP_BITS-1:0] c_OP_JR   = OP_BITS'(5'b10100);
    localparam logic [OP_BITS-1:0] c_OP_JAL  = OP_BITS'(5'b10011);
    localparam logic [OP_BITS-1:0] c_OP_BR   = OP_BITS'(5'b10010);
    localparam logic [OP_BITS-1:0] c_OP_HALT = OP_BITS'(5'b11011);
    localparam logic [3:0]         c_READ_WAIT = 4'(READ_WAIT);

    state_t      r_state;
    logic [3:0]  r_wait;
    logic        r_is_jal;

    logic [OP_BITS-1:0] w_op;
    logic               w_is_jr;
    logic               w_is_jal;
    logic               w_is_br;
    logic               w_is_halt;
    logic               w_read_done;
    logic               w_retire;
    logic [BITS-OP_BITS-1:0] w_unused_ir;

    assign w_op        = ir[BITS-1 -: OP_BITS];
    assign w_unused_ir = ir[BITS-OP_BITS-1:0];
    assign w_is_jr     = (w_op == c_OP_JR);
    assign w_is_jal    = (w_op == c_OP_JAL);
    assign w_is_br     = (w_op == c_OP_BR);
    assign w_is_halt   = (w_op == c_OP_HALT);
    assign w_read_done = (r_wait == c_READ_WAIT);

    // JR and unsupported opcodes finish in T3, JAL in T4, BR in T6.
    assign w_retire = ((r_state == S_T3) && !w_is_jal && !w_is_br && !w_is_halt)
                   || ((r_state == S_T4) && r_is_jal)
                   ||  (r_state == S_T6);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_wait   <= 4'd0;
            r_is_jal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (run) r_state <= S_T0;
                S_T0: begin
                    r_state <= S_T1;
                    r_wait  <= 4'd0;
                end
                S_T1: begin
                    if (w_read_done) r_state <= S_T2;
                    else             r_wait  <= r_wait + 4'd1;
                end
                S_T2: r_state <= S_T3;
                S_T3: begin
                    r_is_jal <= w_is_jal;
                    if (w_is_jal || w_is_br) r_state <= S_T4;
                    else if (w_is_halt)      r_state <= S_HALT;
                    else                     r_state <= run ? S_T0 : S_IDLE;
                end
                S_T4: begin
                    if (r_is_jal) r_state <= run ? S_T0 : S_IDLE;
                    else          r_state <= S_T5;
                end
                S_T5:   r_state <= S_T6;
                S_T6:   r_state <= run ? S_T0 : S_IDLE;
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode straight off the state register; T3 needs the freshly
    // loaded IR and T6 needs the live CON flag, so they cannot be pre-registered.
    always_comb begin
        PCout   = 1'b0;
        MDRout  = 1'b0;
        RZout   = 1'b0;
        Cout    = 1'b0;
        Rout    = 1'b0;
        PCin    = 1'b0;
        IRin    = 1'b0;
        MDRin   = 1'b0;
        MARin   = 1'b0;
        RYin    = 1'b0;
        RZin    = 1'b0;
        CONin   = 1'b0;
        Rin     = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Read    = 1'b0;
        IncPC   = 1'b0;
        ADD     = 1'b0;
        halted  = 1'b0;
        illegal = 1'b0;
        case (r_state)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                RZin  = 1'b1;
            end
            S_T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
                RZout = w_read_done;
                PCin  = w_read_done;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (w_is_jr) begin
                    Gra  = 1'b1;
                    Rout = 1'b1;
                    PCin = 1'b1;
                end else if (w_is_jal) begin
                    PCout = 1'b1;
                    Grb   = 1'b1;
                    Rin   = 1'b1;
                end else if (w_is_br) begin
                    Gra   = 1'b1;
                    Rout  = 1'b1;
                    CONin = 1'b1;
                end else if (!w_is_halt) begin
                    illegal = 1'b1;
                end
            end
            S_T4: begin
                if (r_is_jal) begin
                    Gra  = 1'b1;
                    Rout = 1'b1;
                    PCin = 1'b1;
                end else begin
                    PCout = 1'b1;
                    RYin  = 1'b1;
                end
            end
            S_T5: begin
                Cout = 1'b1;
                ADD  = 1'b1;
                RZin = 1'b1;
            end
            S_T6: begin
                RZout = 1'b1;
                PCin  = con;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign step = r_state;

`ifdef SEQ_RETIRE_COUNT_EN
    logic [COUNT_BITS-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        r_count <= '0;
        else if (w_retire) r_count <= r_count + COUNT_BITS'(1);
    end

    assign instr_count = r_count;
`else
    logic [COUNT_BITS-1:0] w_unused_count;
    logic                  w_unused_retire;

    assign w_unused_count  = '0;
    assign w_unused_retire = w_retire;
`endif

endmodule

`default_nettype wire
